ir_rx_ctrl: RTL and testbench
=============================

IR_RX_CTRL -- requirements
Module: ir_rx_ctrl

Interface
REQ-001 The block SHALL expose parameters, one per line as name, default, meaning:
  DEPTH  4  frame FIFO entries (power of two, 2..16)
  HOLD_W  24  width of repeat-holdoff counter
REQ-002 The block SHALL expose ports, one per line as name, direction, width, meaning:
  csi_CLK  in  1  single system clock, 100 MHz
  csi_RST  in  1  asynchronous, active-high reset
  avs_chipselect  in  1  Avalon slave select
  avs_address  in  3  word register address
  avs_read  in  1  read strobe
  avs_readdata  out  32  read data, registered
  avs_write  in  1  write strobe
  avs_writedata  in  32  write data
  ins_irq  out  1  interrupt request, level, registered
  dec_data  in  32  decoded frame from IR decoder: {cmd_n[31:24], cmd[23:16], addr[15:0]}
  dec_ready  in  1  decoder data-ready level, asynchronous to csi_CLK
  dec_en  out  1  decoder enable, mirrors CTRL.rx_en

Function
REQ-003 dec_ready SHALL pass a 2-flop synchroniser; a 0->1 transition on the synchronised signal SHALL be one frame event; dec_data SHALL be sampled in the event cycle.
REQ-004 Events SHALL be ignored while CTRL.rx_en=0.
REQ-005 A frame SHALL be valid iff dec_data[31:24] == ~dec_data[23:16]; an invalid frame SHALL increment ERR_CNT (8-bit, saturating at 255) and SHALL NOT be stored.
REQ-006 With CTRL.filter_en=1, a valid frame equal to the last stored frame while the holdoff counter is nonzero SHALL be dropped, SHALL increment REP_CNT (8-bit, saturating) and SHALL reload the holdoff counter.
REQ-007 Any stored frame SHALL reload the holdoff counter from HOLDOFF; the counter SHALL decrement by 1 per cycle to 0 and stop.
REQ-008 A valid, unfiltered frame SHALL be pushed to the FIFO if not full; if full it SHALL be dropped and STATUS.ovf set (sticky).
REQ-009 Register map (word address): 0 DATA (R, pop); 1 STATUS (R); 2 CTRL (R/W: [0] rx_en, [1] irq_en, [2] filter_en); 3 CLEAR (W1C: [0] ovf, [1] ERR_CNT, [2] REP_CNT, [3] flush FIFO); 4 HOLDOFF (R/W, [HOLD_W-1:0]); 5-7 read 0, writes ignored.
REQ-010 STATUS SHALL be {ERR_CNT[31:24], REP_CNT[23:16], 4'b0, irq_pend[11], ovf[10], full[9], empty[8], 3'b0, count[4:0]}.
REQ-011 avs_readdata SHALL be valid one cycle after a cycle with avs_chipselect & avs_read; no wait states.
REQ-012 A read of DATA when not empty SHALL return the head frame and pop it; when empty it SHALL return 0 with no state change.
REQ-013 Push and pop in the same cycle SHALL both occur, count unchanged, including when full.
REQ-014 Flush SHALL empty the FIFO; a push in the same cycle SHALL be discarded; flush SHALL not alter ovf.
REQ-015 irq_pend = ~empty | ovf; ins_irq SHALL equal irq_en & irq_pend, registered one cycle after either changes.
REQ-016 Simultaneous CLEAR.ovf and new overflow SHALL leave ovf set; simultaneous CLEAR.ERR_CNT and invalid frame SHALL leave ERR_CNT = 1.
REQ-017 dec_en SHALL equal CTRL.rx_en, registered.

Reset
REQ-018 On csi_RST: FIFO empty, count 0, ovf 0, ERR_CNT 0, REP_CNT 0, CTRL 0, HOLDOFF 0x2FAF08 (~31 ms), holdoff counter 0, last-frame 0, synchroniser 0, avs_readdata 0, ins_irq 0, dec_en 0.
REQ-019 Reset mid-operation SHALL discard all FIFO contents and any in-flight event; no event SHALL be generated by a dec_ready already high at reset release until it falls and rises again.

Structure
REQ-020 Package ir_rx_pkg SHALL hold register address constants, STATUS/CTRL/CLEAR bit positions, HOLDOFF reset value.
REQ-021 FIFO storage and pointers SHALL be sub-module ir_frame_fifo (push, pop, flush, full, empty, count, head).

Verification
REQ-022 rx_en=1, dec_ready pulse with 0xEA15_00FF -> count 1, ins_irq=1 when irq_en=1, DATA read returns 0xEA15_00FF, then empty, ins_irq=0.
REQ-023 Frame 0x1234_00FF (invalid) -> ERR_CNT=1, FIFO empty; 300 invalid frames -> ERR_CNT=255.
REQ-024 filter_en=1, HOLDOFF=1000, same valid frame at t=0,500,1400,2500 cycles -> stored at 0 and 2500 only, REP_CNT=2.
REQ-025 Five valid frames with DEPTH=4, no reads -> count 4, full=1, ovf=1; DATA reads return first four in order.
REQ-026 Full FIFO, DATA read and frame event same cycle -> count stays 4, oldest popped, new frame at tail.
REQ-027 Assert csi_RST with 3 frames queued and dec_ready high -> all outputs at reset values; no event until dec_ready toggles.

Source files
------------

// File: rtl/ir_rx_pkg.sv
// Shared constants, register layout and helpers for the IR receiver controller.
package ir_rx_pkg;

    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_STATUS  = 3'd1;
    localparam logic [2:0] ADDR_CTRL    = 3'd2;
    localparam logic [2:0] ADDR_CLEAR   = 3'd3;
    localparam logic [2:0] ADDR_HOLDOFF = 3'd4;

    localparam int unsigned CTRL_RX_EN     = 0;
    localparam int unsigned CTRL_IRQ_EN    = 1;
    localparam int unsigned CTRL_FILTER_EN = 2;

    localparam int unsigned CLR_OVF   = 0;
    localparam int unsigned CLR_ERR   = 1;
    localparam int unsigned CLR_REP   = 2;
    localparam int unsigned CLR_FLUSH = 3;

    localparam int unsigned STAT_EMPTY = 8;
    localparam int unsigned STAT_FULL  = 9;
    localparam int unsigned STAT_OVF   = 10;
    localparam int unsigned STAT_IRQ   = 11;

    localparam logic [31:0] HOLDOFF_RST = 32'h002F_AF08;

    typedef struct packed {
        logic filter_en;
        logic irq_en;
        logic rx_en;
    } ctrl_t;

    function automatic logic frame_valid(input logic [31:0] frame);
        return frame[31:24] == ~frame[23:16];
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/ir_frame_fifo.sv
// Power-of-two frame FIFO; push while full is accepted only alongside a pop,
// and flush wins over any push or pop in the same cycle.
module ir_frame_fifo
    import ir_rx_pkg::*;
#(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 32,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o,
    output logic [WIDTH-1:0] head_o
);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok_s, pop_ok_s;

    // Accept decisions and pointer/occupancy next state.
    always_comb begin
        pop_ok_s  = pop_i & ~flush_i & (count_q != '0);
        push_ok_s = push_i & ~flush_i & ((count_q != FULL_CNT) | pop_ok_s);
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            wr_ptr_d = push_ok_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
            rd_ptr_d = pop_ok_s  ? rd_ptr_q + AW'(1) : rd_ptr_q;
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Frame storage; contents are only meaningful below the occupancy count.
    always_ff @(posedge clk_i) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/ir_rx_ctrl.sv
// IR receiver controller: synchronises decoder strobes, validates and filters
// frames, queues them and exposes queue, counters and control over Avalon-MM.
module ir_rx_ctrl
    import ir_rx_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int HOLD_W = 24
) (
    input  logic        csi_CLK,
    input  logic        csi_RST,
    input  logic        avs_chipselect,
    input  logic [2:0]  avs_address,
    input  logic        avs_read,
    output logic [31:0] avs_readdata,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic        ins_irq,
    input  logic [31:0] dec_data,
    input  logic        dec_ready,
    output logic        dec_en
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
    logic [1:0]        settle_q, settle_d;
    ctrl_t             ctrl_q, ctrl_d;
    logic [HOLD_W-1:0] holdoff_q, holdoff_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [31:0]       last_q, last_d;
    logic [7:0]        err_q, err_d, rep_q, rep_d;
    logic              ovf_q, ovf_d;
    logic [31:0]       readdata_q, readdata_d;
    logic              irq_q, irq_d, dec_en_q, dec_en_d;

    logic              event_s, invalid_s, repeat_s, push_req_s, store_s, ovf_set_s;
    logic              rd_s, wr_s, pop_s, flush_s, clr_ovf_s, clr_err_s, clr_rep_s;
    logic              fifo_full_s, fifo_empty_s;
    logic [CNT_W-1:0]  fifo_count_s;
    logic [31:0]       fifo_head_s, status_s, rd_mux_s;
    logic              unused_wdata_s;

    assign unused_wdata_s = ^avs_writedata;

    // Frame event classification and bus command decode for this cycle.
    // The settle counter blocks a level already high at reset release from
    // looking like a rising edge while the synchroniser fills.
    always_comb begin
        rd_s       = avs_chipselect & avs_read;
        wr_s       = avs_chipselect & avs_write;
        pop_s      = rd_s & (avs_address == ADDR_DATA) & ~fifo_empty_s;
        flush_s    = wr_s & (avs_address == ADDR_CLEAR) & avs_writedata[CLR_FLUSH];
        clr_ovf_s  = wr_s & (avs_address == ADDR_CLEAR) & avs_writedata[CLR_OVF];
        clr_err_s  = wr_s & (avs_address == ADDR_CLEAR) & avs_writedata[CLR_ERR];
        clr_rep_s  = wr_s & (avs_address == ADDR_CLEAR) & avs_writedata[CLR_REP];
        event_s    = sync2_q & ~prev_q & (settle_q == 2'd3) & ctrl_q.rx_en;
        invalid_s  = event_s & ~frame_valid(dec_data);
        repeat_s   = event_s & frame_valid(dec_data) & ctrl_q.filter_en
                     & (dec_data == last_q) & (hold_q != '0);
        push_req_s = event_s & frame_valid(dec_data) & ~repeat_s & ~flush_s;
        store_s    = push_req_s & (~fifo_full_s | pop_s);
        ovf_set_s  = push_req_s & fifo_full_s & ~pop_s;
    end

    ir_frame_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk_i       (csi_CLK),
        .rst_i       (csi_RST),
        .push_i      (push_req_s),
        .push_data_i (dec_data),
        .pop_i       (pop_s),
        .flush_i     (flush_s),
        .full_o      (fifo_full_s),
        .empty_o     (fifo_empty_s),
        .count_o     (fifo_count_s),
        .head_o      (fifo_head_s)
    );

    // STATUS word and read-data multiplexer.
    always_comb begin
        status_s                   = 32'h0;
        status_s[31:24]            = err_q;
        status_s[23:16]            = rep_q;
        status_s[STAT_IRQ]         = ~fifo_empty_s | ovf_q;
        status_s[STAT_OVF]         = ovf_q;
        status_s[STAT_FULL]        = fifo_full_s;
        status_s[STAT_EMPTY]       = fifo_empty_s;
        status_s[CNT_W-1:0]        = fifo_count_s;
        rd_mux_s                   = 32'h0;
        case (avs_address)
            ADDR_DATA:    rd_mux_s = fifo_empty_s ? 32'h0 : fifo_head_s;
            ADDR_STATUS:  rd_mux_s = status_s;
            ADDR_CTRL:    rd_mux_s = {29'h0, ctrl_q};
            ADDR_HOLDOFF: rd_mux_s[HOLD_W-1:0] = holdoff_q;
            default:      rd_mux_s = 32'h0;
        endcase
    end

    // Next state for every control/status register.
    always_comb begin
        sync1_d  = dec_ready;
        sync2_d  = sync1_q;
        prev_d   = sync2_q;
        settle_d = (settle_q == 2'd3) ? settle_q : settle_q + 2'd1;

        ctrl_d    = ctrl_q;
        holdoff_d = holdoff_q;
        if (wr_s && (avs_address == ADDR_CTRL)) begin
            ctrl_d.rx_en     = avs_writedata[CTRL_RX_EN];
            ctrl_d.irq_en    = avs_writedata[CTRL_IRQ_EN];
            ctrl_d.filter_en = avs_writedata[CTRL_FILTER_EN];
        end else if (wr_s && (avs_address == ADDR_HOLDOFF)) begin
            holdoff_d = avs_writedata[HOLD_W-1:0];
        end else begin
            ctrl_d    = ctrl_q;
            holdoff_d = holdoff_q;
        end

        if (store_s || repeat_s) begin
            hold_d = holdoff_q;
        end else if (hold_q != '0) begin
            hold_d = hold_q - HOLD_W'(1);
        end else begin
            hold_d = hold_q;
        end
        last_d = store_s ? dec_data : last_q;

        // A clear coinciding with a new increment leaves exactly that increment.
        if (clr_err_s) begin
            err_d = invalid_s ? 8'd1 : 8'd0;
        end else if (invalid_s) begin
            err_d = sat_inc8(err_q);
        end else begin
            err_d = err_q;
        end
        if (clr_rep_s) begin
            rep_d = repeat_s ? 8'd1 : 8'd0;
        end else if (repeat_s) begin
            rep_d = sat_inc8(rep_q);
        end else begin
            rep_d = rep_q;
        end
        ovf_d = (ovf_q & ~clr_ovf_s) | ovf_set_s;

        readdata_d = rd_s ? rd_mux_s : readdata_q;
        irq_d      = ctrl_q.irq_en & (~fifo_empty_s | ovf_q);
        dec_en_d   = ctrl_q.rx_en;
    end

    // State registers.
    always_ff @(posedge csi_CLK or posedge csi_RST) begin
        if (csi_RST) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            prev_q     <= 1'b0;
            settle_q   <= 2'd0;
            ctrl_q     <= '0;
            holdoff_q  <= HOLDOFF_RST[HOLD_W-1:0];
            hold_q     <= '0;
            last_q     <= 32'h0;
            err_q      <= 8'd0;
            rep_q      <= 8'd0;
            ovf_q      <= 1'b0;
            readdata_q <= 32'h0;
            irq_q      <= 1'b0;
            dec_en_q   <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            prev_q     <= prev_d;
            settle_q   <= settle_d;
            ctrl_q     <= ctrl_d;
            holdoff_q  <= holdoff_d;
            hold_q     <= hold_d;
            last_q     <= last_d;
            err_q      <= err_d;
            rep_q      <= rep_d;
            ovf_q      <= ovf_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
            dec_en_q   <= dec_en_d;
        end
    end

    assign avs_readdata = readdata_q;
    assign ins_irq      = irq_q;
    assign dec_en       = dec_en_q;

endmodule

// File: tb/tb_ir_rx_ctrl.sv
// Self-checking bench for ir_rx_ctrl against a queue-based model of the receiver.
module tb_ir_rx_ctrl;
    localparam int DEPTH = 4;
    localparam logic [2:0] A_DATA = 3'd0, A_STAT = 3'd1, A_CTRL = 3'd2;
    localparam logic [2:0] A_CLR = 3'd3, A_HOLD = 3'd4;

    logic        clk = 1'b0, rst = 1'b1;
    logic        cs = 1'b0, rd_en = 1'b0, wr_en = 1'b0;
    logic [2:0]  addr = 3'd0;
    logic [31:0] wdata = 32'h0, rdata, ddata = 32'h0;
    logic        irq, dready = 1'b0, den;

    int unsigned cyc = 0;
    int          n_cmp = 0, n_bad = 0;

    logic [31:0] m_q [$];
    logic [7:0]  m_err, m_rep;
    logic        m_ovf, m_rx, m_irq_en, m_filter, m_hold_valid;
    logic [31:0] m_last;
    int unsigned m_hold_stamp, m_holdoff;

    ir_rx_ctrl #(.DEPTH(DEPTH), .HOLD_W(24)) dut (
        .csi_CLK(clk), .csi_RST(rst), .avs_chipselect(cs), .avs_address(addr),
        .avs_read(rd_en), .avs_readdata(rdata), .avs_write(wr_en), .avs_writedata(wdata),
        .ins_irq(irq), .dec_data(ddata), .dec_ready(dready), .dec_en(den)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #900000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1);
    end

    function automatic void model_reset();
        m_q.delete();
        m_err = 8'd0; m_rep = 8'd0; m_ovf = 1'b0; m_last = 32'h0;
        m_rx = 1'b0; m_irq_en = 1'b0; m_filter = 1'b0; m_hold_valid = 1'b0;
        m_hold_stamp = 0; m_holdoff = 32'h002F_AF08;
    endfunction

    // A frame event at cycle stamp, applied with the plain receive rules.
    function automatic void model_event(logic [31:0] f, int unsigned stamp);
        if (!m_rx) return;
        if (f[31:24] != ~f[23:16]) begin
            if (m_err != 8'd255) m_err = m_err + 8'd1;
            return;
        end
        if (m_filter && f == m_last && m_hold_valid && (stamp - m_hold_stamp) <= m_holdoff) begin
            if (m_rep != 8'd255) m_rep = m_rep + 8'd1;
            m_hold_stamp = stamp;
            return;
        end
        if (m_q.size() == DEPTH) begin
            m_ovf = 1'b1;
            return;
        end
        m_q.push_back(f);
        m_last = f; m_hold_stamp = stamp; m_hold_valid = 1'b1;
    endfunction

    function automatic logic [31:0] model_status();
        logic [31:0] s;
        s = 32'h0;
        s[31:24] = m_err; s[23:16] = m_rep;
        s[11] = (m_q.size() != 0) || m_ovf;
        s[10] = m_ovf;
        s[9]  = (m_q.size() == DEPTH);
        s[8]  = (m_q.size() == 0);
        s[4:0] = 5'(m_q.size());
        return s;
    endfunction

    function automatic logic [31:0] model_pop();
        if (m_q.size() == 0) return 32'h0;
        return m_q.pop_front();
    endfunction

    function automatic logic [31:0] rand_frame(bit valid);
        logic [31:0] f;
        f = $urandom;
        f[31:24] = valid ? ~f[23:16] : (~f[23:16] ^ 8'($urandom_range(1, 255)));
        return f;
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        cs = 1'b1; wr_en = 1'b1; addr = a; wdata = d;
        tick();
        cs = 1'b0; wr_en = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        cs = 1'b1; rd_en = 1'b1; addr = a;
        tick();
        cs = 1'b0; rd_en = 1'b0;
        d = rdata;
    endtask

    // The frame is processed on the third edge after dec_ready rises.
    task automatic send_frame(input logic [31:0] f, output int unsigned stamp);
        ddata = f; dready = 1'b1;
        repeat (3) tick();
        stamp = cyc;
        tick();
        dready = 1'b0;
        repeat (4) tick();
    endtask

    task automatic wait_until(input int unsigned t);
        while (cyc < t) tick();
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst = 1'b1; repeat (2) tick();
        n_cmp++;
        if ({rdata, irq, den} !== 34'h0) begin
            n_bad++; $display("FAIL reset_outputs: got %h/%b/%b expected 0/0/0", rdata, irq, den);
        end
        rst = 1'b0; model_reset(); tick();
        bus_read(A_STAT, d);
        n_cmp++; if (d !== model_status()) begin n_bad++; $display("FAIL reset_status: got %h expected %h", d, model_status()); end
        bus_read(A_CTRL, d);
        n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL reset_ctrl: got %h expected 0", d); end
        bus_read(A_HOLD, d);
        n_cmp++; if (d !== 32'h002F_AF08) begin n_bad++; $display("FAIL reset_holdoff: got %h expected 002faf08", d); end
        bus_read(A_DATA, d);
        n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL reset_data_empty: got %h expected 0", d); end
        bus_write(3'd6, 32'hFFFF_FFFF);
        bus_read(3'd6, d);
        n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL unmapped_read: got %h expected 0", d); end
    endtask

    task automatic test_basic();
        logic [31:0] d;
        int unsigned st;
        bus_write(A_CTRL, 32'h3); m_rx = 1'b1; m_irq_en = 1'b1;
        tick();
        n_cmp++; if (den !== 1'b1) begin n_bad++; $display("FAIL dec_en: got %b expected 1", den); end
        send_frame(32'hEA15_00FF, st); model_event(32'hEA15_00FF, st);
        n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL basic_irq_set: got %b expected 1", irq); end
        bus_read(A_STAT, d);
        n_cmp++; if (d !== model_status()) begin n_bad++; $display("FAIL basic_status: got %h expected %h", d, model_status()); end
        bus_read(A_DATA, d);
        n_cmp++; if (d !== 32'hEA15_00FF) begin n_bad++; $display("FAIL basic_data: got %h expected ea1500ff", d); end
        void'(model_pop());
        tick();
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL basic_irq_clear: got %b expected 0", irq); end
        bus_read(A_STAT, d);
        n_cmp++; if (d !== model_status()) begin n_bad++; $display("FAIL basic_empty: got %h expected %h", d, model_status()); end
    endtask

    task automatic test_invalid();
        logic [31:0] d, f;
        int unsigned st;
        send_frame(32'h1234_00FF, st); model_event(32'h1234_00FF, st);
        bus_read(A_STAT, d);
        n_cmp++; if (d !== model_status() || d[31:24] !== 8'd1) begin
            n_bad++; $display("FAIL invalid_one: got %h expected %h", d, model_status());
        end
        for (int i = 0; i < 299; i++) begin
            f = rand_frame(1'b0);
            send_frame(f, st); model_event(f, st);
        end
        bus_read(A_STAT, d);
        n_cmp++; if (d[31:24] !== 8'd255 || d !== model_status()) begin
            n_bad++; $display("FAIL invalid_saturate: got %h expected %h", d, model_status());
        end
        ddata = 32'h5555_0000; dready = 1'b1;
        repeat (2) tick();
        bus_write(A_CLR, 32'h2);
        m_err = 8'd1;
        dready = 1'b0; repeat (4) tick();
        bus_read(A_STAT, d);
        n_cmp++; if (d[31:24] !== 8'd1) begin n_bad++; $display("FAIL clear_vs_err: got %0d expected 1", d[31:24]); end
        bus_write(A_CLR, 32'h2); m_err = 8'd0;
    endtask

    task automatic test_filter();
        logic [31:0] d;
        int unsigned st0, st;
        bus_write(A_CLR, 32'h7); m_err = 8'd0; m_rep = 8'd0; m_ovf = 1'b0;
        bus_write(A_HOLD, 32'd1000); m_holdoff = 1000;
        bus_write(A_CTRL, 32'h5); m_rx = 1'b1; m_irq_en = 1'b0; m_filter = 1'b1;
        send_frame(32'h7F80_ABCD, st0); model_event(32'h7F80_ABCD, st0);
        wait_until(st0 + 497); send_frame(32'h7F80_ABCD, st); model_event(32'h7F80_ABCD, st);
        wait_until(st0 + 1397); send_frame(32'h7F80_ABCD, st); model_event(32'h7F80_ABCD, st);
        wait_until(st0 + 2497); send_frame(32'h7F80_ABCD, st); model_event(32'h7F80_ABCD, st);
        bus_read(A_STAT, d);
        n_cmp++; if (d[23:16] !== 8'd2 || d[4:0] !== 5'd2 || d !== model_status()) begin
            n_bad++; $display("FAIL filter_status: got %h expected %h", d, model_status());
        end
        for (int i = 0; i < 2; i++) begin
            bus_read(A_DATA, d);
            n_cmp++; if (d !== 32'h7F80_ABCD) begin n_bad++; $display("FAIL filter_data%0d: got %h expected 7f80abcd", i, d); end
            void'(model_pop());
        end
    endtask

    task automatic test_overflow();
        logic [31:0] d, f, e;
        int unsigned st;
        bus_write(A_CLR, 32'h7); m_rep = 8'd0;
        bus_write(A_CTRL, 32'h1); m_filter = 1'b0;
        for (int i = 0; i < 5; i++) begin
            f = rand_frame(1'b1);
            send_frame(f, st); model_event(f, st);
        end
        bus_read(A_STAT, d);
        n_cmp++; if (d[11:8] !== 4'hE || d[4:0] !== 5'd4 || d !== model_status()) begin
            n_bad++; $display("FAIL overflow_status: got %h expected %h", d, model_status());
        end
        for (int i = 0; i < 4; i++) begin
            bus_read(A_DATA, d); e = model_pop();
            n_cmp++; if (d !== e) begin n_bad++; $display("FAIL overflow_data%0d: got %h expected %h", i, d, e); end
        end
        bus_write(A_CLR, 32'h1); m_ovf = 1'b0;
        bus_read(A_STAT, d);
        n_cmp++; if (d !== model_status()) begin n_bad++; $display("FAIL ovf_clear: got %h expected %h", d, model_status()); end
    endtask

    task automatic test_full_push_pop();
        logic [31:0] d, f, e;
        int unsigned st;
        for (int i = 0; i < 4; i++) begin
            f = rand_frame(1'b1);
            send_frame(f, st); model_event(f, st);
        end
        f = rand_frame(1'b1);
        ddata = f; dready = 1'b1;
        repeat (2) tick();
        bus_read(A_DATA, d); e = model_pop(); model_event(f, cyc);
        dready = 1'b0; repeat (4) tick();
        n_cmp++; if (d !== e) begin n_bad++; $display("FAIL pushpop_head: got %h expected %h", d, e); end
        bus_read(A_STAT, d);
        n_cmp++; if (d[4:0] !== 5'd4 || d !== model_status()) begin
            n_bad++; $display("FAIL pushpop_status: got %h expected %h", d, model_status());
        end
        for (int i = 0; i < 4; i++) begin
            bus_read(A_DATA, d); e = model_pop();
            n_cmp++; if (d !== e) begin n_bad++; $display("FAIL pushpop_data%0d: got %h expected %h", i, d, e); end
        end
        for (int i = 0; i < 2; i++) begin
            f = rand_frame(1'b1);
            send_frame(f, st); model_event(f, st);
        end
        ddata = rand_frame(1'b1); dready = 1'b1;
        repeat (2) tick();
        bus_write(A_CLR, 32'h8); m_q.delete();
        dready = 1'b0; repeat (4) tick();
        bus_read(A_STAT, d);
        n_cmp++; if (d !== model_status()) begin n_bad++; $display("FAIL flush_push: got %h expected %h", d, model_status()); end
    endtask

    task automatic test_random();
        logic [31:0] d, f, e;
        logic [31:0] pool [3];
        int unsigned st, k;
        for (int i = 0; i < 3; i++) pool[i] = rand_frame(1'b1);
        bus_write(A_HOLD, 32'd16); m_holdoff = 16;
        bus_write(A_CTRL, 32'h7); m_irq_en = 1'b1; m_filter = 1'b1;
        for (int i = 0; i < 90; i++) begin
            if ($urandom_range(0, 9) < 4) begin
                bus_read(A_DATA, d); e = model_pop();
                n_cmp++; if (d !== e) begin n_bad++; $display("FAIL random_data it%0d: got %h expected %h", i, d, e); end
            end else begin
                k = $urandom_range(0, 3);
                f = (k == 3) ? rand_frame(1'b0) : pool[k];
                send_frame(f, st); model_event(f, st);
            end
            repeat ($urandom_range(0, 12)) tick();
            if (i % 15 == 14) begin
                bus_read(A_STAT, d);
                n_cmp++; if (d !== model_status()) begin n_bad++; $display("FAIL random_status it%0d: got %h expected %h", i, d, model_status()); end
                n_cmp++; if (irq !== (m_irq_en & ((m_q.size() != 0) | m_ovf))) begin
                    n_bad++; $display("FAIL random_irq it%0d: got %b expected %b", i, irq, ~irq);
                end
            end
        end
    endtask

    task automatic test_reset_midop();
        logic [31:0] d, f;
        int unsigned st;
        bus_write(A_CLR, 32'hF); m_q.delete(); m_ovf = 1'b0; m_err = 8'd0; m_rep = 8'd0;
        bus_write(A_CTRL, 32'h3); m_filter = 1'b0;
        for (int i = 0; i < 3; i++) begin
            f = rand_frame(1'b1);
            send_frame(f, st); model_event(f, st);
        end
        bus_read(A_STAT, d);
        ddata = rand_frame(1'b1); dready = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        n_cmp++; if ({rdata, irq, den} !== 34'h0) begin
            n_bad++; $display("FAIL midop_reset_outputs: got %h/%b/%b expected 0/0/0", rdata, irq, den);
        end
        rst = 1'b0; model_reset();
        bus_write(A_CTRL, 32'h1); m_rx = 1'b1;
        repeat (10) tick();
        bus_read(A_STAT, d);
        n_cmp++; if (d !== model_status()) begin n_bad++; $display("FAIL midop_no_event: got %h expected %h", d, model_status()); end
        dready = 1'b0; repeat (4) tick();
        f = rand_frame(1'b1);
        send_frame(f, st); model_event(f, st);
        bus_read(A_STAT, d);
        n_cmp++; if (d !== model_status()) begin n_bad++; $display("FAIL midop_rearm: got %h expected %h", d, model_status()); end
        bus_read(A_DATA, d);
        n_cmp++; if (d !== f) begin n_bad++; $display("FAIL midop_data: got %h expected %h", d, f); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_invalid();
        test_filter();
        test_overflow();
        test_full_push_pop();
        test_random();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
